// File: rtl/note_lane_dropper.sv
// Rhythm-lane arrow engine: spawns, moves, judges and scores up to NOTES arrows per frame.
// Build option GHOST_PENALTY_EN: a press with an empty hit window also counts as one miss.
module note_lane_dropper #(
   parameter int          NOTES        = 4,
   parameter int          TOTAL_NOTES  = 16,
   parameter int          START_DELAY  = 160,
   parameter int          SPAWN_PERIOD = 60,
   parameter int          SPEED        = 1,
   parameter int          X_POS        = 440,
   parameter int          Y_START      = 100,
   parameter int          NOTE_H       = 40,
   parameter int          WIN_LO       = 340,
   parameter int          Y_MAX        = 400,
   parameter logic [7:0]  HIT_KEY      = 8'h52,
   parameter logic [7:0]  START_KEY    = 8'h2c,
   parameter logic [7:0]  RESTART_KEY  = 8'h01
) (
   input  logic                  frame_clk,
   input  logic                  Reset,
   input  logic [7:0]            keycode,
   input  logic [7:0]            keycode_second,
   output logic [9:0]            dropX,
   output logic [10*NOTES-1:0]   dropY,
   output logic [NOTES-1:0]      note_valid,
   output logic                  hit_pulse,
   output logic                  miss_pulse,
   output logic [7:0]            score,
   output logic [7:0]            misses,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

   // state is the observable FSM register for external checkers.
   state_t            state, state_nx;
   logic [9:0]        y_q  [NOTES];
   logic [9:0]        y_nx [NOTES];
   logic [NOTES-1:0]  valid_q, valid_nx;
   logic              hit_q, hit_nx, miss_q, miss_nx;
   logic [7:0]        score_q, score_nx, misses_q, misses_nx;
   logic [7:0]        spawned_q, spawned_nx;
   logic [15:0]       timer_q, timer_nx;
   logic              key_prev, key_now, press, start_key, restart_key;

   logic [NOTES-1:0]  hit_sel;
   logic              hit_found, ghost, spawn_done;
   logic [9:0]        best_y;
   logic [3:0]        miss_cnt;
   logic [8:0]        miss_sum;

   // Bottom edge in 11 bits so Y near the top of the 10-bit range cannot wrap.
   function automatic logic [10:0] bottom(input logic [9:0] y);
      return {1'b0, y} + 11'(NOTE_H);
   endfunction

   assign key_now     = (keycode == HIT_KEY)     || (keycode_second == HIT_KEY);
   assign start_key   = (keycode == START_KEY)   || (keycode_second == START_KEY);
   assign restart_key = (keycode == RESTART_KEY) || (keycode_second == RESTART_KEY);
   assign press       = key_now && !key_prev;

   always_comb begin
      state_nx   = state;
      y_nx       = y_q;
      valid_nx   = valid_q;
      hit_nx     = 1'b0;
      miss_nx    = 1'b0;
      score_nx   = score_q;
      misses_nx  = misses_q;
      spawned_nx = spawned_q;
      timer_nx   = timer_q;
      hit_sel    = '0;
      hit_found  = 1'b0;
      best_y     = '0;
      miss_cnt   = '0;
      ghost      = 1'b0;
      miss_sum   = '0;
      spawn_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_key) begin
               state_nx = PLAY;
               timer_nx = 16'(START_DELAY);
            end
         end
         PLAY: begin
            // Strict '>' keeps the lowest index on equal Y.
            for (int i = 0; i < NOTES; i++) begin
               if (valid_q[i] && bottom(y_q[i]) >= 11'(WIN_LO) && bottom(y_q[i]) < 11'(Y_MAX)
                   && (!hit_found || y_q[i] > best_y)) begin
                  hit_sel    = '0;
                  hit_sel[i] = 1'b1;
                  hit_found  = 1'b1;
                  best_y     = y_q[i];
               end
            end
            if (press && hit_found) begin
               valid_nx = valid_q & ~hit_sel;
               hit_nx   = 1'b1;
               if (score_q != 8'hFF) score_nx = score_q + 8'd1;
            end
`ifdef GHOST_PENALTY_EN
            ghost = press && !hit_found;
`else
            ghost = 1'b0;
`endif
            for (int i = 0; i < NOTES; i++) begin
               if (valid_nx[i]) begin
                  y_nx[i] = y_q[i] + 10'(SPEED);
                  if (bottom(y_nx[i]) >= 11'(Y_MAX)) begin
                     valid_nx[i] = 1'b0;
                     miss_cnt    = miss_cnt + 4'd1;
                  end
               end
            end
            miss_sum = {1'b0, misses_q} + 9'(miss_cnt) + 9'(ghost);
            if (miss_cnt != 4'd0 || ghost) begin
               miss_nx   = 1'b1;
               misses_nx = miss_sum[8] ? 8'hFF : miss_sum[7:0];
            end
            // Slots freed by the hit or miss above are already free here.
            if (timer_q != 16'd0) begin
               timer_nx = timer_q - 16'd1;
            end else if (spawned_q < 8'(TOTAL_NOTES)) begin
               for (int i = 0; i < NOTES; i++) begin
                  if (!valid_nx[i] && !spawn_done) begin
                     valid_nx[i] = 1'b1;
                     y_nx[i]     = 10'(Y_START);
                     spawned_nx  = spawned_q + 8'd1;
                     timer_nx    = 16'(SPAWN_PERIOD - 1);
                     spawn_done  = 1'b1;
                  end
               end
            end
            if (spawned_nx == 8'(TOTAL_NOTES) && valid_nx == '0) state_nx = DONE;
         end
         DONE: begin
            if (restart_key) begin
               state_nx   = IDLE;
               valid_nx   = '0;
               score_nx   = '0;
               misses_nx  = '0;
               spawned_nx = '0;
               timer_nx   = '0;
               for (int i = 0; i < NOTES; i++) y_nx[i] = 10'(Y_START);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state     <= IDLE;
         valid_q   <= '0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         score_q   <= '0;
         misses_q  <= '0;
         spawned_q <= '0;
         timer_q   <= '0;
         key_prev  <= 1'b0;
         for (int i = 0; i < NOTES; i++) y_q[i] <= 10'(Y_START);
      end else begin
         state     <= state_nx;
         valid_q   <= valid_nx;
         hit_q     <= hit_nx;
         miss_q    <= miss_nx;
         score_q   <= score_nx;
         misses_q  <= misses_nx;
         spawned_q <= spawned_nx;
         timer_q   <= timer_nx;
         key_prev  <= key_now;
         for (int i = 0; i < NOTES; i++) y_q[i] <= y_nx[i];
      end
   end

   for (genvar g = 0; g < NOTES; g++) begin : g_dropy
      assign dropY[10*g +: 10] = y_q[g];
   end

   assign dropX      = 10'(X_POS);
   assign note_valid = valid_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign score      = score_q;
   assign misses     = misses_q;
   assign done       = (state == DONE);

endmodule

// File: tb/tb_note_lane_dropper.sv
// Bench for note_lane_dropper: three parameterisations in lockstep against an arrow-age reference model.
module tb_note_lane_dropper;

   localparam logic [7:0] HIT = 8'h52, START = 8'h2c, RESTART = 8'h01;
`ifdef GHOST_PENALTY_EN
   localparam int GHOST = 1;
`else
   localparam int GHOST = 0;
`endif

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00, keycode_second = 8'h00;

   always #5 frame_clk = ~frame_clk;

   logic [9:0]  a_dropX, b_dropX, c_dropX;
   logic [39:0] a_dropY;
   logic [9:0]  b_dropY;
   logic [19:0] c_dropY;
   logic [3:0]  a_nv;
   logic [0:0]  b_nv;
   logic [1:0]  c_nv;
   logic        a_hit, b_hit, c_hit, a_miss, b_miss, c_miss, a_done, b_done, c_done;
   logic [7:0]  a_score, b_score, c_score, a_misses, b_misses, c_misses;

   note_lane_dropper dut_a (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
      .dropX(a_dropX), .dropY(a_dropY), .note_valid(a_nv), .hit_pulse(a_hit), .miss_pulse(a_miss),
      .score(a_score), .misses(a_misses), .done(a_done));

   note_lane_dropper #(.NOTES(1), .TOTAL_NOTES(16), .START_DELAY(5), .SPAWN_PERIOD(10), .SPEED(1)) dut_b (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
      .dropX(b_dropX), .dropY(b_dropY), .note_valid(b_nv), .hit_pulse(b_hit), .miss_pulse(b_miss),
      .score(b_score), .misses(b_misses), .done(b_done));

   note_lane_dropper #(.NOTES(2), .TOTAL_NOTES(255), .START_DELAY(2), .SPAWN_PERIOD(3), .SPEED(15)) dut_c (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .keycode_second(keycode_second),
      .dropX(c_dropX), .dropY(c_dropY), .note_valid(c_nv), .hit_pulse(c_hit), .miss_pulse(c_miss),
      .score(c_score), .misses(c_misses), .done(c_done));

   // Reference: an arrow's Y is derived from its age in frames, not tracked per cycle.
   typedef struct {
      int notes, total, start_delay, period, speed;
      int st;          // 0 idle, 1 play, 2 done
      int frame;
      bit valid [8];
      int birth [8];
      int timer, spawned, score, misses;
      bit hit_p, miss_p, prev;
   } model_t;

   model_t       m [3];
   int           n_vec = 0, n_bad = 0;
   logic [127:0] obs [3];

   function automatic int model_y(input model_t mm, input int i);
      return 100 + mm.speed * (mm.frame - mm.birth[i]);
   endfunction

   function automatic logic [127:0] pack(input logic [7:0] nv, input logic [79:0] dy, input logic hit,
                                         input logic miss, input logic [7:0] sc, input logic [7:0] ms,
                                         input logic dn);
      logic [127:0] p;
      p = '0;
      p[7:0] = nv;
      for (int i = 0; i < 8; i++) if (nv[i]) p[8+10*i +: 10] = dy[10*i +: 10];
      p[88] = hit;
      p[89] = miss;
      p[97:90] = sc;
      p[105:98] = ms;
      p[106] = dn;
      return p;
   endfunction

   function automatic logic [127:0] model_pack(input model_t mm);
      logic [127:0] p;
      p = '0;
      for (int i = 0; i < mm.notes; i++) begin
         if (mm.valid[i]) begin
            p[i] = 1'b1;
            p[8+10*i +: 10] = 10'(model_y(mm, i));
         end
      end
      p[88] = mm.hit_p;
      p[89] = mm.miss_p;
      p[97:90] = 8'(mm.score);
      p[105:98] = 8'(mm.misses);
      p[106] = (mm.st == 2);
      return p;
   endfunction

   assign obs[0] = pack(8'(a_nv), 80'(a_dropY), a_hit, a_miss, a_score, a_misses, a_done);
   assign obs[1] = pack(8'(b_nv), 80'(b_dropY), b_hit, b_miss, b_score, b_misses, b_done);
   assign obs[2] = pack(8'(c_nv), 80'(c_dropY), c_hit, c_miss, c_score, c_misses, c_done);

   task automatic model_step(inout model_t mm, input logic [7:0] k1, input logic [7:0] k2, input logic rst);
      bit key, press, any;
      int yb [8];
      int best, nm, add, ghost;
      key = (k1 == HIT) || (k2 == HIT);
      press = key && !mm.prev;
      mm.prev = rst ? 1'b0 : key;
      mm.hit_p = 0;
      mm.miss_p = 0;
      if (rst) begin
         mm.st = 0; mm.frame = 0; mm.timer = 0; mm.spawned = 0; mm.score = 0; mm.misses = 0;
         for (int i = 0; i < 8; i++) begin mm.valid[i] = 0; mm.birth[i] = 0; end
         return;
      end
      case (mm.st)
         0: if (k1 == START || k2 == START) begin mm.st = 1; mm.timer = mm.start_delay; end
         1: begin
            for (int i = 0; i < 8; i++) yb[i] = model_y(mm, i);
            best = -1;
            for (int i = 0; i < mm.notes; i++)
               if (mm.valid[i] && yb[i] + 40 >= 340 && yb[i] + 40 < 400 && (best < 0 || yb[i] > yb[best]))
                  best = i;
            ghost = 0;
            if (press) begin
               if (best >= 0) begin
                  mm.valid[best] = 0;
                  mm.score = (mm.score + 1 > 255) ? 255 : mm.score + 1;
                  mm.hit_p = 1;
               end else begin
                  ghost = GHOST;
               end
            end
            nm = 0;
            for (int i = 0; i < mm.notes; i++)
               if (mm.valid[i] && yb[i] + mm.speed + 40 >= 400) begin mm.valid[i] = 0; nm++; end
            add = nm + ghost;
            if (add > 0) begin
               mm.misses = (mm.misses + add > 255) ? 255 : mm.misses + add;
               mm.miss_p = 1;
            end
            mm.frame++;
            if (mm.timer > 0) mm.timer--;
            else if (mm.spawned < mm.total) begin
               for (int i = 0; i < mm.notes; i++) begin
                  if (!mm.valid[i]) begin
                     mm.valid[i] = 1; mm.birth[i] = mm.frame; mm.spawned++; mm.timer = mm.period - 1;
                     break;
                  end
               end
            end
            any = 0;
            for (int i = 0; i < mm.notes; i++) any |= mm.valid[i];
            if (mm.spawned == mm.total && !any) mm.st = 2;
         end
         2: if (k1 == RESTART || k2 == RESTART) begin
            mm.st = 0; mm.timer = 0; mm.spawned = 0; mm.score = 0; mm.misses = 0;
            for (int i = 0; i < 8; i++) mm.valid[i] = 0;
         end
         default: mm.st = 0;
      endcase
   endtask

   task automatic tick();
      @(posedge frame_clk);
      for (int d = 0; d < 3; d++) model_step(m[d], keycode, keycode_second, Reset);
      #1;
   endtask

   task automatic drive_random();
      keycode = ($urandom_range(0, 9) < 3) ? HIT : 8'($urandom_range(8'h60, 8'hff));
      if ($urandom_range(0, 15) == 0)      keycode_second = HIT;
      else if ($urandom_range(0, 31) == 0) keycode_second = START;
      else                                 keycode_second = 8'($urandom_range(8'h60, 8'hff));
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(); tick();
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (obs[d] !== model_pack(m[d])) begin
            n_bad++; $display("FAIL reset_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
         end
      end
      n_vec++;
      if (a_dropY !== {4{10'd100}} || a_nv !== 4'b0 || a_done !== 1'b0 || a_dropX !== 10'd440) begin
         n_bad++; $display("FAIL reset_vals got y=%h nv=%b done=%b x=%0d exp y=all 100 nv=0 done=0 x=440",
                           a_dropY, a_nv, a_done, a_dropX);
      end
      Reset = 1'b0;
   endtask

   task automatic test_idle_keys();
      for (int k = 0; k < 6; k++) begin
         keycode = (k % 2 == 0) ? HIT : RESTART;
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL idle_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
            end
         end
      end
      keycode = 8'h00;
      tick();
      n_vec++;
      if (a_score !== 8'd0 || a_nv !== 4'b0 || a_hit !== 1'b0) begin
         n_bad++; $display("FAIL idle_hold got score=%0d nv=%b hit=%b exp 0 0 0", a_score, a_nv, a_hit);
      end
   endtask

   task automatic test_schedule();
      keycode = START;
      tick();
      for (int c = 1; c <= 430; c++) begin
         keycode = (c == 100) ? RESTART : (c == 200) ? START : 8'h00;
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL sched_pack dut%0d c=%0d got %h exp %h", d, c, obs[d], model_pack(m[d]));
            end
         end
         if (c == 160) begin
            n_vec++;
            if (a_nv !== 4'b0000) begin n_bad++; $display("FAIL early_spawn got nv=%b exp 0000", a_nv); end
         end
         if (c == 161) begin
            n_vec++;
            if (a_nv !== 4'b0001 || a_dropY[9:0] !== 10'd100) begin
               n_bad++; $display("FAIL first_spawn got nv=%b y0=%0d exp 0001 100", a_nv, a_dropY[9:0]);
            end
         end
         if (c == 265) begin
            n_vec++;
            if (b_nv !== 1'b1 || b_dropY !== 10'd359 || b_misses !== 8'd0) begin
               n_bad++; $display("FAIL b_before_miss got nv=%b y=%0d mis=%0d exp 1 359 0", b_nv, b_dropY, b_misses);
            end
         end
         if (c == 266) begin
            n_vec++;
            if (b_nv !== 1'b1 || b_dropY !== 10'd100 || b_misses !== 8'd1 || b_miss !== 1'b1) begin
               n_bad++; $display("FAIL b_deferred_spawn got nv=%b y=%0d mis=%0d mp=%b exp 1 100 1 1",
                                 b_nv, b_dropY, b_misses, b_miss);
            end
         end
         if (c == 421) begin
            n_vec++;
            if (a_nv !== 4'b1111 || a_miss !== 1'b1 || a_misses !== 8'd1 || a_dropY[9:0] !== 10'd100) begin
               n_bad++; $display("FAIL first_miss got nv=%b mp=%b mis=%0d y0=%0d exp 1111 1 1 100",
                                 a_nv, a_miss, a_misses, a_dropY[9:0]);
            end
         end
         if (c == 422) begin
            n_vec++;
            if (a_miss !== 1'b0 || a_misses !== 8'd1) begin
               n_bad++; $display("FAIL miss_pulse_len got mp=%b mis=%0d exp 0 1", a_miss, a_misses);
            end
         end
      end
   endtask

   task automatic test_run_to_done();
      bit all_done;
      all_done = 0;
      for (int k = 0; k < 20000 && !all_done; k++) begin
         drive_random();
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL run_pack dut%0d k=%0d got %h exp %h", d, k, obs[d], model_pack(m[d]));
            end
         end
         all_done = (m[0].st == 2) && (m[1].st == 2) && (m[2].st == 2);
      end
      keycode = 8'h00;
      keycode_second = 8'h00;
      n_vec++;
      if (!all_done || a_done !== 1'b1 || b_done !== 1'b1 || c_done !== 1'b1) begin
         n_bad++; $display("FAIL run_done got done=%b%b%b reached=%0d exp 111 1", a_done, b_done, c_done, all_done);
      end
   endtask

   task automatic test_restart();
      keycode = START;
      tick();
      n_vec++;
      if (a_done !== 1'b1 || c_done !== 1'b1) begin
         n_bad++; $display("FAIL start_in_done got a=%b c=%b exp 1 1", a_done, c_done);
      end
      keycode = RESTART;
      tick();
      n_vec++;
      if (a_done !== 1'b0 || a_score !== 8'd0 || a_misses !== 8'd0 || a_nv !== 4'b0) begin
         n_bad++; $display("FAIL restart got done=%b sc=%0d mis=%0d nv=%b exp 0 0 0 0", a_done, a_score, a_misses, a_nv);
      end
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (obs[d] !== model_pack(m[d])) begin
            n_bad++; $display("FAIL restart_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
         end
      end
      keycode = 8'h00;
      tick();
   endtask

   task automatic test_hit_hold();
      bit found, busy;
      keycode = START;
      tick();
      keycode = 8'h00;
      found = 0;
      for (int k = 0; k < 1000 && !found; k++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL hh_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
            end
         end
         for (int i = 0; i < 4; i++) if (m[0].valid[i] && model_y(m[0], i) == 310) found = 1;
      end
      n_vec++;
      if (!found) begin n_bad++; $display("FAIL wait_y310 got timeout exp arrow at 310"); end
      keycode = HIT;
      tick();
      n_vec++;
      if (a_score !== 8'd1 || a_hit !== 1'b1 || a_nv[0] !== 1'b0) begin
         n_bad++; $display("FAIL hit got sc=%0d hp=%b nv0=%b exp 1 1 0", a_score, a_hit, a_nv[0]);
      end
      for (int k = 0; k < 60; k++) begin
         tick();
         n_vec++;
         if (a_score !== 8'd1 || a_hit !== 1'b0) begin
            n_bad++; $display("FAIL hold k=%0d got sc=%0d hp=%b exp 1 0", k, a_score, a_hit);
         end
      end
      keycode = 8'h00;
      tick();
      keycode = HIT;
      tick();
      n_vec++;
      if (a_score !== 8'd2 || a_hit !== 1'b1) begin
         n_bad++; $display("FAIL second_hit got sc=%0d hp=%b exp 2 1", a_score, a_hit);
      end
      keycode = 8'h00;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL gh_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
            end
         end
         busy = 0;
         for (int i = 0; i < 4; i++)
            if (m[0].valid[i] && model_y(m[0], i) + 40 >= 340 && model_y(m[0], i) + 40 < 400) busy = 1;
         for (int i = 0; i < 4; i++) if (m[0].valid[i] && model_y(m[0], i) == 299 && !busy) found = 1;
      end
      n_vec++;
      if (!found) begin n_bad++; $display("FAIL wait_y299 got timeout exp arrow at 299"); end
      keycode = HIT;
      tick();
      n_vec++;
      if (a_hit !== 1'b0 || a_score !== 8'd2 || a_misses !== 8'(GHOST) || a_miss !== 1'(GHOST)) begin
         n_bad++; $display("FAIL early_press got hp=%b sc=%0d mis=%0d mp=%b exp 0 2 %0d %0d",
                           a_hit, a_score, a_misses, a_miss, GHOST, GHOST);
      end
      keycode = 8'h00;
      tick();
      test_run_to_done();
   endtask

   task automatic test_reset_mid_play();
      keycode = RESTART;
      tick();
      keycode = START;
      tick();
      for (int k = 0; k < 700; k++) begin
         drive_random();
         tick();
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (obs[d] !== model_pack(m[d])) begin
               n_bad++; $display("FAIL mid_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
            end
         end
      end
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      n_vec++;
      if (a_nv !== 4'b0 || a_score !== 8'd0 || a_misses !== 8'd0 || a_done !== 1'b0 || a_hit !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset got nv=%b sc=%0d mis=%0d done=%b hp=%b exp 0 0 0 0 0",
                           a_nv, a_score, a_misses, a_done, a_hit);
      end
      keycode = HIT;
      keycode_second = 8'h00;
      tick(); tick();
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (obs[d] !== model_pack(m[d])) begin
            n_bad++; $display("FAIL post_reset_pack dut%0d got %h exp %h", d, obs[d], model_pack(m[d]));
         end
      end
      keycode = 8'h00;
   endtask

   initial begin
      m[0].notes = 4; m[0].total = 16;  m[0].start_delay = 160; m[0].period = 60; m[0].speed = 1;
      m[1].notes = 1; m[1].total = 16;  m[1].start_delay = 5;   m[1].period = 10; m[1].speed = 1;
      m[2].notes = 2; m[2].total = 255; m[2].start_delay = 2;   m[2].period = 3;  m[2].speed = 15;
      test_reset();
      test_idle_keys();
      test_schedule();
      test_run_to_done();
      test_restart();
      test_hit_hold();
      test_restart();
      test_reset_mid_play();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/note_lane_dropper.md
Name: note_lane_dropper

Overview:
- Parametrised successor of the single-arrow lane dropper: one rhythm lane with up to NOTES arrows in flight at once.
- Spawns TOTAL_NOTES arrows on a fixed frame schedule and moves each down by SPEED per frame.
- Judges hit/miss per arrow and keeps saturating score and miss counters.
- Sits between the keyboard keycode path and the lane sprite/colour mapper; runs on the frame clock.

Parameters:
NOTES, 4, number of concurrent arrow slots (1..8)
TOTAL_NOTES, 16, arrows spawned per song (1..255)
START_DELAY, 160, frames from start to first spawn
SPAWN_PERIOD, 60, frames between spawn attempts (>=1)
SPEED, 1, pixels per frame added to each active arrow's Y (1..15)
X_POS, 440, fixed lane X
Y_START, 100, spawn Y (top edge)
NOTE_H, 40, arrow height in pixels
WIN_LO, 340, hit window lower bound on bottom edge (inclusive)
Y_MAX, 400, miss line on bottom edge; also hit window upper bound (exclusive)
HIT_KEY, 8'h52, lane key
START_KEY, 8'h2c, start key
RESTART_KEY, 8'h01, restart key

Ports:
frame_clk  in  1  frame clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
keycode  in  8  primary key code
keycode_second  in  8  secondary key code
dropX  out  10  lane X, constant X_POS
dropY  out  10*NOTES  packed Y per slot, slot i at [10i+9:10i]
note_valid  out  NOTES  slot active mask
hit_pulse  out  1  one-cycle pulse on a judged hit
miss_pulse  out  1  one-cycle pulse when one or more misses are counted
score  out  8  hit count, saturates at 255
misses  out  8  miss count, saturates at 255
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE. note_valid=0, all dropY=Y_START, hit_pulse=miss_pulse=0, score=misses=0, done=0, spawn count=0, timers=0, key history=0. Reset wins over every other event.
- Key match: key_now = (keycode==HIT_KEY)|(keycode_second==HIT_KEY). press = key_now & ~key_prev, where key_prev is registered every cycle. Holding the key does not repeat.
- IDLE:
  - Outputs held at reset values.
  - START_KEY on either input -> PLAY, with timer loaded with START_DELAY.
- PLAY, each frame in this order:
  1. Hit: if press, take the valid slot with the largest Y whose bottom (Y+NOTE_H, computed in 11 bits) satisfies WIN_LO<=bottom<Y_MAX. Clear that slot, score+=1 (sat), hit_pulse=1. At most one slot per press. Ties go to the lowest index.
  2. Move: every remaining valid slot gets Y+=SPEED.
  3. Miss: after the move, any valid slot with bottom>=Y_MAX is cleared. misses += count of such slots (saturating). miss_pulse=1 if count>0.
  4. Spawn: timer decrements each frame. At 0, if spawned<TOTAL_NOTES and a free slot exists (slots freed this cycle count as free), the lowest free index gets Y=Y_START and valid=1, spawned+=1, and timer reloads SPAWN_PERIOD-1. If no slot is free, timer holds at 0 and the spawn retries each frame.
  5. If spawned==TOTAL_NOTES and no slot is valid after steps 1-4 -> DONE next cycle.
- DONE:
  - done=1; slots invalid; score and misses held.
  - RESTART_KEY on either input -> IDLE (counters clear on entry to IDLE).
- A newly spawned slot is neither moved nor judged in its spawn cycle.
- Pulses are registered and last exactly one cycle.
- START_KEY in PLAY/DONE and RESTART_KEY in IDLE/PLAY are ignored.

Optional Feature:
GHOST_PENALTY_EN:
- Defined: a press in PLAY with no valid slot in the window gives misses+=1 (sat) and miss_pulse=1 that cycle. This is added to any same-cycle miss count.
- Undefined: such presses have no effect.

Test Plan:
- Reset mid-PLAY with 3 slots valid, score=5 -> next cycle note_valid=0, score=0, misses=0, state IDLE, done=0.
- START_KEY, defaults, no presses -> first spawn at frame 161 into slot 0 with Y=100. Slot reaches bottom 400 after 260 moves, then misses=1 and a one-cycle miss_pulse. After 16 arrows: misses=16, done=1.
- Press HIT_KEY for 1 cycle when slot 0 has Y=310 (bottom 350) -> slot 0 cleared, score=1, hit_pulse one cycle. Holding the key 10 more cycles with another arrow in the window leaves score=1.
- Bottom=339 with a press -> no hit, and misses unchanged unless GHOST_PENALTY_EN (then misses+1).
- NOTES=1, SPAWN_PERIOD=10 -> second spawn is deferred until slot 0 frees, then spawns in the same cycle it frees. Total spawned still equals 16.
- Two arrows in the window plus a press -> only the larger-Y arrow is cleared, score+1. With TOTAL_NOTES=300 equivalent (255 reached), score saturates at 255.
